// File: rtl/fir_structs_pkg.sv
// Shared types for the complex FIR filter and its drivers.
//   Samp        : I/Q sample pair, signed 1.23 each.
//   Coef        : I/Q coefficient pair, signed 3.24 each.
//   src_state_t : firc_source sequencing states.
package fir_structs;

  localparam int unsigned NUM_COEF_WORDS = 15;
  localparam int unsigned SAMP_W         = 24;
  localparam int unsigned COEF_W         = 27;

  typedef struct packed {
    logic signed [SAMP_W-1:0] I;
    logic signed [SAMP_W-1:0] Q;
  } Samp;

  typedef struct packed {
    logic signed [COEF_W-1:0] I;
    logic signed [COEF_W-1:0] Q;
  } Coef;

  typedef enum logic [1:0] {
    STREAM,
    FLUSH,
    LOAD,
    GAP
  } src_state_t;

endpackage

// File: rtl/coef_shadow_bank.sv
// Shadow coefficient register file: NUM x {I,Q} words.
//   clk, Reset : clock, synchronous active-high reset (clears every word)
//   we_i       : write strobe, waddr_i/wdata_i write port
//   raddr_i    : asynchronous read address, rdata_o read data
//                (out-of-range addresses read as zero)
module coef_shadow_bank
  import fir_structs::*;
#(
  parameter int unsigned NUM = NUM_COEF_WORDS,
  parameter int unsigned AW  = $clog2(NUM_COEF_WORDS)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  Coef           wdata_i,
  input  logic [AW-1:0] raddr_i,
  output Coef           rdata_o
);

  Coef mem_q [NUM];

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < NUM)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < NUM) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/firc_source.sv
// Transmit-side driver for the complex FIR filter input interface.
//   clk, Reset          : clock, synchronous active-high reset
//   InValid/InReady     : upstream sample handshake, InI/InQ sample data
//   CfgWe/CfgAddr/CfgI/Q: shadow coefficient bank write port
//   CfgLoad             : request to stream the shadow bank to the filter
//   Busy                : high while flushing, loading or in the post-load gap
//   CfgDrop             : sticky flag, a config write or load was discarded
//   PushIn/SampI/SampQ  : sample push to the filter, gated by StopIn
//   PushCoef/CoefAddr/CoefI/CoefQ : coefficient write port to the filter
module firc_source
  import fir_structs::*;
#(
  parameter int unsigned NUM_COEF   = NUM_COEF_WORDS,
  parameter int unsigned GAP_CYCLES = 1  // must be >= 1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic signed [23:0] InI,
  input  logic signed [23:0] InQ,
  input  logic               CfgWe,
  input  logic [4:0]         CfgAddr,
  input  logic signed [26:0] CfgI,
  input  logic signed [26:0] CfgQ,
  input  logic               CfgLoad,
  output logic               Busy,
  output logic               CfgDrop,
  output logic               PushIn,
  input  logic               StopIn,
  output logic signed [23:0] SampI,
  output logic signed [23:0] SampQ,
  output logic               PushCoef,
  output logic [4:0]         CoefAddr,
  output logic signed [26:0] CoefI,
  output logic signed [26:0] CoefQ
);

  localparam int unsigned    AW       = $clog2(NUM_COEF);
  localparam logic [AW-1:0]  CNT_ONE  = AW'(1);
  localparam logic [AW-1:0]  CNT_LAST = AW'(NUM_COEF - 1);
  localparam logic [7:0]     GAP_LAST = 8'(GAP_CYCLES - 1);

  src_state_t    state_q;
  logic          hold_v_q;
  Samp           hold_q;
  logic          load_pend_q;
  logic          cfg_drop_q;
  logic          push_coef_q;
  logic [4:0]    coef_addr_q;
  Coef           coef_q;
  logic [AW-1:0] cnt_q;
  logic [7:0]    gap_cnt_q;

  logic          accept_d;
  logic          bank_we_d;
  logic          load_req_d;
  logic [AW-1:0] rd_addr_d;
  Coef           bank_wdata_d;
  Coef           bank_rdata_d;

  assign Busy     = (state_q != STREAM);
  // The held sample may still drain while flushing ahead of a load.
  assign PushIn   = hold_v_q && !StopIn && ((state_q == STREAM) || (state_q == FLUSH));
  assign InReady  = (state_q == STREAM) && !load_pend_q && (!hold_v_q || PushIn);
  assign accept_d = InValid && InReady;

  assign bank_we_d    = CfgWe && !Busy && (32'(CfgAddr) < NUM_COEF);
  assign load_req_d   = CfgLoad && !Busy && !load_pend_q;
  assign bank_wdata_d = '{I: CfgI, Q: CfgQ};

  // Address of the word presented on the next PushCoef cycle: entry 0 when
  // leaving FLUSH, otherwise the successor of the word now on the bus.
  assign rd_addr_d = (state_q == LOAD) ? (cnt_q + CNT_ONE) : '0;

  coef_shadow_bank #(
    .NUM (NUM_COEF),
    .AW  (AW)
  ) u_bank (
    .clk     (clk),
    .Reset   (Reset),
    .we_i    (bank_we_d),
    .waddr_i (CfgAddr[AW-1:0]),
    .wdata_i (bank_wdata_d),
    .raddr_i (rd_addr_d),
    .rdata_o (bank_rdata_d)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= STREAM;
      hold_v_q    <= 1'b0;
      hold_q      <= '0;
      load_pend_q <= 1'b0;
      cfg_drop_q  <= 1'b0;
      push_coef_q <= 1'b0;
      coef_addr_q <= '0;
      coef_q      <= '0;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
    end else begin
      if ((CfgWe && Busy) || (CfgLoad && (Busy || load_pend_q))) begin
        cfg_drop_q <= 1'b1;
      end

      if (accept_d) begin
        hold_q   <= '{I: InI, Q: InQ};
        hold_v_q <= 1'b1;
      end else if (PushIn) begin
        hold_v_q <= 1'b0;
      end

      push_coef_q <= 1'b0;

      unique case (state_q)
        // Entering FLUSH on the request edge itself keeps the load two
        // cycles behind CfgLoad when nothing is held.
        STREAM: begin
          if (load_req_d || load_pend_q) begin
            load_pend_q <= 1'b1;
            state_q     <= FLUSH;
          end
        end
        FLUSH: begin
          if (!hold_v_q) begin
            state_q     <= LOAD;
            cnt_q       <= rd_addr_d;
            push_coef_q <= 1'b1;
            coef_addr_q <= 5'(rd_addr_d);
            coef_q      <= bank_rdata_d;
          end
        end
        LOAD: begin
          if (cnt_q == CNT_LAST) begin
            state_q   <= GAP;
            gap_cnt_q <= '0;
          end else begin
            cnt_q       <= rd_addr_d;
            push_coef_q <= 1'b1;
            coef_addr_q <= 5'(rd_addr_d);
            coef_q      <= bank_rdata_d;
          end
        end
        GAP: begin
          if (gap_cnt_q >= GAP_LAST) begin
            state_q     <= STREAM;
            load_pend_q <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= STREAM;
      endcase
    end
  end

  assign CfgDrop  = cfg_drop_q;
  assign SampI    = hold_q.I;
  assign SampQ    = hold_q.Q;
  assign PushCoef = push_coef_q;
  assign CoefAddr = coef_addr_q;
  assign CoefI    = coef_q.I;
  assign CoefQ    = coef_q.Q;

endmodule

// File: tb/tb_firc_source.sv
module tb_firc_source;

  logic               clk;
  logic               Reset;
  logic               InValid;
  logic               InReady;
  logic signed [23:0] InI, InQ;
  logic               CfgWe;
  logic [4:0]         CfgAddr;
  logic signed [26:0] CfgI, CfgQ;
  logic               CfgLoad;
  logic               Busy;
  logic               CfgDrop;
  logic               PushIn;
  logic               StopIn;
  logic signed [23:0] SampI, SampQ;
  logic               PushCoef;
  logic [4:0]         CoefAddr;
  logic signed [26:0] CoefI, CoefQ;

  int checks = 0;
  int errors = 0;

  // Expected shadow bank contents, maintained by the bench.
  logic signed [26:0] mi [15];
  logic signed [26:0] mq [15];

  firc_source #(
    .NUM_COEF   (15),
    .GAP_CYCLES (1)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .InI      (InI),
    .InQ      (InQ),
    .CfgWe    (CfgWe),
    .CfgAddr  (CfgAddr),
    .CfgI     (CfgI),
    .CfgQ     (CfgQ),
    .CfgLoad  (CfgLoad),
    .Busy     (Busy),
    .CfgDrop  (CfgDrop),
    .PushIn   (PushIn),
    .StopIn   (StopIn),
    .SampI    (SampI),
    .SampQ    (SampQ),
    .PushCoef (PushCoef),
    .CoefAddr (CoefAddr),
    .CoefI    (CoefI),
    .CoefQ    (CoefQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #1;
    checks++; if (PushCoef !== 1'b0) begin errors++; $display("FAIL reset_pushcoef got=%b exp=0", PushCoef); end
    checks++; if (CoefAddr !== 5'd0) begin errors++; $display("FAIL reset_coefaddr got=%0d exp=0", CoefAddr); end
    checks++; if ({CoefI, CoefQ} !== 54'd0) begin errors++; $display("FAIL reset_coefdata got=%h/%h exp=0/0", CoefI, CoefQ); end
    checks++; if ({SampI, SampQ} !== 48'd0) begin errors++; $display("FAIL reset_samp got=%h/%h exp=0/0", SampI, SampQ); end
    checks++; if (CfgDrop !== 1'b0) begin errors++; $display("FAIL reset_cfgdrop got=%b exp=0", CfgDrop); end
    checks++; if (PushIn !== 1'b0) begin errors++; $display("FAIL reset_pushin got=%b exp=0", PushIn); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    Reset = 1'b0;
    tick();
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got=%b exp=1", InReady); end
  endtask

  task automatic test_stream();
    int sent = 0, got = 0, first_acc = -1, first_push = -1, last_push = -1;
    logic acc;
    for (int c = 0; c < 300 && got < 100; c++) begin
      InValid = (sent < 100);
      InI = 24'(sent);
      InQ = 24'(-sent);
      #1;
      if (PushIn) begin
        checks++;
        if (SampI !== 24'(got) || SampQ !== 24'(-got)) begin
          errors++; $display("FAIL stream_data k=%0d got=%0d/%0d exp=%0d/%0d", got, SampI, SampQ, got, -got);
        end
        if (first_push < 0) first_push = c;
        last_push = c;
        got++;
      end
      acc = InValid && InReady;
      if (acc && first_acc < 0) first_acc = c;
      tick();
      if (acc) sent++;
    end
    InValid = 1'b0;
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count got=%0d exp=100", got); end
    checks++; if (first_push != first_acc + 1) begin errors++; $display("FAIL stream_latency got=%0d exp=%0d", first_push, first_acc + 1); end
    checks++; if (last_push - first_push != 99) begin errors++; $display("FAIL stream_b2b got=%0d exp=99", last_push - first_push); end
  endtask

  task automatic test_stopin();
    int sent = 0, got = 0;
    logic acc;
    for (int c = 0; c < 100 && got < 20; c++) begin
      StopIn  = (c >= 5 && c < 12);
      InValid = (sent < 20);
      InI = 24'(1000 + sent);
      InQ = 24'(-(1000 + sent));
      #1;
      if (StopIn) begin
        checks++; if (PushIn !== 1'b0) begin errors++; $display("FAIL stop_pushin c=%0d got=%b exp=0", c, PushIn); end
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL stop_inready c=%0d got=%b exp=0", c, InReady); end
      end
      if (PushIn) begin
        checks++;
        if (SampI !== 24'(1000 + got) || SampQ !== 24'(-(1000 + got))) begin
          errors++; $display("FAIL stop_data k=%0d got=%0d/%0d exp=%0d", got, SampI, SampQ, 1000 + got);
        end
        got++;
      end
      acc = InValid && InReady;
      tick();
      if (acc) sent++;
    end
    StopIn = 1'b0;
    InValid = 1'b0;
    checks++; if (got != 20) begin errors++; $display("FAIL stop_count got=%0d exp=20", got); end
    #1;
    checks++; if (PushIn !== 1'b0) begin errors++; $display("FAIL stop_nodup got=%b exp=0", PushIn); end
  endtask

  task automatic test_coef_load();
    bit exp_pc;
    for (int a = 0; a < 15; a++) begin
      CfgWe = 1'b1;
      CfgAddr = 5'(a);
      CfgI = 27'(32'h100000 + a);
      CfgQ = 27'(-a);
      mi[a] = 27'(32'h100000 + a);
      mq[a] = 27'(-a);
      CfgLoad = (a == 14);  // last write shares the cycle with the load request
      tick();
    end
    CfgWe = 1'b0;
    CfgLoad = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      InValid = 1'b1;
      InI = 24'd777;
      InQ = -24'sd777;
      #1;
      exp_pc = (c >= 2 && c <= 16);
      checks++; if (PushCoef !== exp_pc) begin errors++; $display("FAIL load_pushcoef c=%0d got=%b exp=%b", c, PushCoef, exp_pc); end
      checks++; if (Busy !== (c <= 17)) begin errors++; $display("FAIL load_busy c=%0d got=%b exp=%b", c, Busy, c <= 17); end
      checks++; if (InReady !== (c == 18)) begin errors++; $display("FAIL load_inready c=%0d got=%b exp=%b", c, InReady, c == 18); end
      checks++; if (PushIn !== 1'b0) begin errors++; $display("FAIL load_pushin c=%0d got=%b exp=0", c, PushIn); end
      if (exp_pc) begin
        checks++;
        if (CoefAddr !== 5'(c - 2) || CoefI !== mi[c-2] || CoefQ !== mq[c-2]) begin
          errors++; $display("FAIL load_coef c=%0d got=%0d:%h/%h exp=%0d:%h/%h", c, CoefAddr, CoefI, CoefQ, c - 2, mi[c-2], mq[c-2]);
        end
      end
      tick();
    end
    InValid = 1'b0;
    #1;
    checks++;
    if (PushIn !== 1'b1 || SampI !== 24'sd777) begin
      errors++; $display("FAIL load_resume got=%b/%0d exp=1/777", PushIn, SampI);
    end
    tick();
  endtask

  task automatic test_load_held();
    bit exp_pc;
    StopIn = 1'b1;
    InValid = 1'b1;
    InI = 24'sd555;
    InQ = -24'sd555;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL held_accept got=%b exp=1", InReady); end
    tick();
    InValid = 1'b0;
    CfgLoad = 1'b1;
    #1;
    checks++; if (PushIn !== 1'b0) begin errors++; $display("FAIL held_stop0 got=%b exp=0", PushIn); end
    tick();
    CfgLoad = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      StopIn = (c <= 3);
      #1;
      exp_pc = (c >= 6 && c <= 20);
      checks++; if (PushIn !== (c == 4)) begin errors++; $display("FAIL held_pushin c=%0d got=%b exp=%b", c, PushIn, c == 4); end
      if (c == 4) begin
        checks++;
        if (SampI !== 24'sd555 || SampQ !== -24'sd555) begin
          errors++; $display("FAIL held_data got=%0d/%0d exp=555/-555", SampI, SampQ);
        end
      end
      checks++; if (PushCoef !== exp_pc) begin errors++; $display("FAIL held_pushcoef c=%0d got=%b exp=%b", c, PushCoef, exp_pc); end
      checks++; if (Busy !== (c <= 21)) begin errors++; $display("FAIL held_busy c=%0d got=%b exp=%b", c, Busy, c <= 21); end
      checks++; if (InReady !== (c == 22)) begin errors++; $display("FAIL held_inready c=%0d got=%b exp=%b", c, InReady, c == 22); end
      if (exp_pc) begin
        checks++;
        if (CoefAddr !== 5'(c - 6) || CoefI !== mi[c-6] || CoefQ !== mq[c-6]) begin
          errors++; $display("FAIL held_coef c=%0d got=%0d:%h exp=%0d:%h", c, CoefAddr, CoefI, c - 6, mi[c-6]);
        end
      end
      tick();
    end
    StopIn = 1'b0;
  endtask

  task automatic test_drops();
    int n;
    // Out-of-range address: ignored, no drop, bank[4] must not alias.
    CfgWe = 1'b1;
    CfgAddr = 5'd20;
    CfgI = 27'h5A5A5A5;
    CfgQ = 27'h1111111;
    tick();
    CfgWe = 1'b0;
    #1;
    checks++; if (CfgDrop !== 1'b0) begin errors++; $display("FAIL drop_addr20 got=%b exp=0", CfgDrop); end
    CfgLoad = 1'b1;
    tick();
    CfgLoad = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      CfgWe = (c == 5);
      CfgAddr = 5'd3;
      CfgI = 27'h0555555;
      CfgQ = 27'h0001234;
      CfgLoad = (c == 17);
      #1;
      if (c == 5) begin
        checks++; if (CfgDrop !== 1'b0) begin errors++; $display("FAIL drop_before got=%b exp=0", CfgDrop); end
      end
      if (c == 6) begin
        checks++; if (CfgDrop !== 1'b1) begin errors++; $display("FAIL drop_we_load got=%b exp=1", CfgDrop); end
      end
      if (c >= 2 && c <= 16) begin
        checks++;
        if (CoefI !== mi[c-2] || CoefQ !== mq[c-2]) begin
          errors++; $display("FAIL drop_coef a=%0d got=%h/%h exp=%h/%h", c - 2, CoefI, CoefQ, mi[c-2], mq[c-2]);
        end
      end
      if (c >= 18) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL drop_gapload c=%0d got=%b exp=0", c, Busy); end
      end
      tick();
    end
    CfgWe = 1'b0;
    CfgLoad = 1'b0;
    checks++; if (CfgDrop !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%b exp=1", CfgDrop); end
    // Reload to confirm the dropped write never reached bank[3].
    CfgLoad = 1'b1;
    tick();
    CfgLoad = 1'b0;
    n = 0;
    for (int c = 1; c <= 18; c++) begin
      #1;
      if (PushCoef) begin
        checks++;
        if (CoefAddr !== 5'(n) || CoefI !== mi[n] || CoefQ !== mq[n]) begin
          errors++; $display("FAIL drop_reload a=%0d got=%0d:%h/%h exp=%h/%h", n, CoefAddr, CoefI, CoefQ, mi[n], mq[n]);
        end
        n++;
      end
      tick();
    end
    checks++; if (n != 15) begin errors++; $display("FAIL drop_reload_count got=%0d exp=15", n); end
  endtask

  task automatic test_reset_mid_load();
    int n;
    CfgLoad = 1'b1;
    tick();
    CfgLoad = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      if (c == 7) begin
        checks++;
        if (PushCoef !== 1'b1 || CoefAddr !== 5'd5) begin
          errors++; $display("FAIL rst_sixth got=%b:%0d exp=1:5", PushCoef, CoefAddr);
        end
        Reset = 1'b1;
      end
      tick();
    end
    Reset = 1'b0;
    #1;
    checks++; if (PushCoef !== 1'b0) begin errors++; $display("FAIL rst_pushcoef got=%b exp=0", PushCoef); end
    checks++; if (CoefAddr !== 5'd0) begin errors++; $display("FAIL rst_coefaddr got=%0d exp=0", CoefAddr); end
    checks++; if ({CoefI, CoefQ} !== 54'd0) begin errors++; $display("FAIL rst_coefdata got=%h/%h exp=0/0", CoefI, CoefQ); end
    checks++; if ({SampI, SampQ} !== 48'd0) begin errors++; $display("FAIL rst_samp got=%h/%h exp=0/0", SampI, SampQ); end
    checks++; if (CfgDrop !== 1'b0) begin errors++; $display("FAIL rst_cfgdrop got=%b exp=0", CfgDrop); end
    checks++; if (Busy !== 1'b0 || PushIn !== 1'b0) begin errors++; $display("FAIL rst_busy_push got=%b/%b exp=0/0", Busy, PushIn); end
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      checks++;
      if (PushCoef !== 1'b0 || InReady !== 1'b1) begin
        errors++; $display("FAIL rst_quiet c=%0d got=%b/%b exp=0/1", c, PushCoef, InReady);
      end
    end
    for (int a = 0; a < 15; a++) begin
      mi[a] = '0;
      mq[a] = '0;
    end
    CfgLoad = 1'b1;
    tick();
    CfgLoad = 1'b0;
    n = 0;
    for (int c = 1; c <= 18; c++) begin
      #1;
      if (PushCoef) begin
        checks++;
        if (CoefAddr !== 5'(n) || CoefI !== mi[n] || CoefQ !== mq[n]) begin
          errors++; $display("FAIL rst_zero_coef a=%0d got=%0d:%h/%h exp=%0d:0/0", n, CoefAddr, CoefI, CoefQ, n);
        end
        n++;
      end
      tick();
    end
    checks++; if (n != 15) begin errors++; $display("FAIL rst_zero_count got=%0d exp=15", n); end
  endtask

  initial begin
    Reset   = 1'b1;
    InValid = 1'b0;
    InI     = '0;
    InQ     = '0;
    CfgWe   = 1'b0;
    CfgAddr = '0;
    CfgI    = '0;
    CfgQ    = '0;
    CfgLoad = 1'b0;
    StopIn  = 1'b0;
    for (int a = 0; a < 15; a++) begin
      mi[a] = '0;
      mq[a] = '0;
    end
    test_reset();
    test_stream();
    test_stopin();
    test_coef_load();
    test_load_held();
    test_drops();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
